pool_out_packer: RTL

Downstream neighbour of the pooling stage. Collects the byte-wide pooled results emitted by the max/avg pooling datapath and packs PACK of them into one output-buffer word. Writes those words to the output SRAM at consecutive addresses, with backpressure on both sides. A small word FIFO decouples the pooling cadence from SRAM write stalls.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_out_packer_if.sv | 30 +++
 rtl/pool_word_fifo.sv | 57 +++++
 rtl/pool_out_packer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and defaults for the pooling output packer
package pool_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Packed output-buffer word as seen by the output SRAM: lane 0 in data LSBs.
  typedef struct packed {
    logic [PACK_DEF-1:0]                strb;
    logic [PACK_DEF*DATA_WIDTH_DEF-1:0] data;
  } word_t;

endpackage

// File: rtl/pool_out_packer_if.sv
// rtl/pool_out_packer_if.sv - element stream and output-buffer write interfaces
interface pool_elem_if
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

interface pool_wr_if
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK       = PACK_DEF
);
  logic                       wr_en;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [PACK*DATA_WIDTH-1:0] wr_data;
  logic [PACK-1:0]            wr_strb;
  logic                       wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, output wr_strb, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, input wr_strb, output wr_ready);
endinterface

// File: rtl/pool_word_fifo.sv
// rtl/pool_word_fifo.sv - small synchronous FIFO holding packed words
module pool_word_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Flags come straight from the pointer registers, so they only change after an edge.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == PW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; a push into a full FIFO is dropped, pop of empty is ignored.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage and pointers; reset discards any queued words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/pool_out_packer.sv
// rtl/pool_out_packer.sv - packs pooled bytes into words and writes them to the output buffer
module pool_out_packer
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK       = PACK_DEF,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_elems,
  pool_elem_if.slave            in_if,
  pool_wr_if.master             wr_if,
  output logic                  busy,
  output logic                  done
);
  localparam int W      = PACK * DATA_WIDTH;
  localparam int LANE_W = $clog2(PACK);
  localparam int FW     = PACK * (DATA_WIDTH + 1);
  localparam int CNTW   = $clog2(FIFO_DEPTH) + 1;

  state_t                state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [W-1:0]          pack_q, pack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic            fifo_full, fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic [FW-1:0]   fifo_head;
  logic            accept, last_elem, push, pop;
  logic [W-1:0]    word_now;
  logic [PACK-1:0] strb_now;

  assign in_if.in_ready = (state_q == RUN) && !fifo_full;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign last_elem      = (rem_q == CNT_WIDTH'(1));
  assign push           = accept && (last_elem || (lane_q == LANE_W'(PACK - 1)));
  assign pop            = wr_if.wr_en && wr_if.wr_ready;

  assign wr_if.wr_en   = !fifo_empty;
  assign wr_if.wr_addr = addr_q;
  assign wr_if.wr_data = fifo_head[W-1:0];
  assign wr_if.wr_strb = fifo_head[FW-1:W];
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);

  // Pack register with the incoming element dropped into its lane, and the fill strobe.
  always_comb begin
    word_now = pack_q;
    word_now[lane_q*DATA_WIDTH +: DATA_WIDTH] = in_if.in_data;
    strb_now = '0;
    for (int i = 0; i < PACK; i++) strb_now[i] = (i <= int'(lane_q));
  end

  pool_word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({strb_now, word_now}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next state, lane/element counters, pack register and write address.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    rem_d   = rem_q;
    pack_d  = pack_q;
    addr_d  = addr_q;
    if (pop) addr_d = addr_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = num_elems;
          lane_d  = '0;
          pack_d  = '0;
          state_d = (num_elems != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept) begin
          rem_d = rem_q - 1'b1;
          if (push) begin
            lane_d = '0;
            pack_d = '0;
          end else begin
            lane_d = lane_q + 1'b1;
            pack_d = word_now;
          end
          if (last_elem) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish as soon as the final queued word is taken, so done follows that write directly.
        if (fifo_empty || (pop && fifo_count == CNTW'(1))) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      rem_q   <= '0;
      pack_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      rem_q   <= rem_d;
      pack_q  <= pack_d;
      addr_q  <= addr_d;
    end
  end

endmodule
